// File: rtl/imm_narrow_if.sv
// Handshake and result bundle for the immediate encoder: producer-side value
// stream in, encoded immediate stream out.
interface imm_narrow_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] imm;
  logic [1:0]  sel;
  logic        sign_ext;
  logic        fits;
  logic [7:0]  miss_count;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, imm, sel, sign_ext, fits, miss_count
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, imm, sel, sign_ext, fits, miss_count
  );
endinterface

// File: rtl/imm_narrow.sv
// Two-stage immediate encoder: picks the narrowest (width, extension) pair that
// the 16-bit immediate extender expands back to exactly the presented value.
module imm_narrow #(
  parameter bit ALLOW_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  imm_narrow_if.slave bus
);

  // Result packing: {fits, sel[1:0], sign_ext, imm[10:0]}
  function automatic logic [14:0] encode(input logic [15:0] v);
    logic [14:0] res;
    if ((&v[15:4]) || !(|v[15:4])) begin
      res = {1'b1, 2'b00, 1'b1, 6'd0, v[4:0]};
    end else if (ALLOW_ZERO && !(|v[15:5])) begin
      res = {1'b1, 2'b00, 1'b0, 6'd0, v[4:0]};
    end else if ((&v[15:7]) || !(|v[15:7])) begin
      res = {1'b1, 2'b01, 1'b1, 3'd0, v[7:0]};
    end else if (ALLOW_ZERO && !(|v[15:8])) begin
      res = {1'b1, 2'b01, 1'b0, 3'd0, v[7:0]};
    end else if ((&v[15:10]) || !(|v[15:10])) begin
      res = {1'b1, 2'b10, 1'b1, v[10:0]};
    end else if (ALLOW_ZERO && !(|v[15:11])) begin
      res = {1'b1, 2'b10, 1'b0, v[10:0]};
    end else begin
      res = {1'b0, 2'b11, 1'b0, 11'd0};
    end
    return res;
  endfunction

  logic        s1_valid_r;
  logic [15:0] s1_value_r;
  logic        s2_valid_r;
  logic [14:0] result_r;
  logic [7:0]  miss_count_r;
  logic        s2_adv_s;
  logic        in_ready_s;
  logic        miss_take_s;

  // S2 may load whenever it is empty or its result is being consumed this cycle.
  assign s2_adv_s    = !s2_valid_r || bus.out_ready;
  assign in_ready_s  = !s1_valid_r || s2_adv_s;
  assign miss_take_s = s2_valid_r && bus.out_ready && !result_r[14];

  // Stage 1: capture the incoming value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_value_r <= 16'd0;
    end else if (in_ready_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_value_r <= bus.value;
      end
    end
  end

  // Stage 2: registered encoding, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= 15'd0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= encode(s1_value_r);
      end
    end
  end

  // Saturating count of delivered no-fit results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_r <= 8'd0;
    end else if (miss_take_s && (miss_count_r != 8'hFF)) begin
      miss_count_r <= miss_count_r + 8'd1;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = s2_valid_r;
  assign bus.fits       = result_r[14];
  assign bus.sel        = result_r[13:12];
  assign bus.sign_ext   = result_r[11];
  assign bus.imm        = result_r[10:0];
  assign bus.miss_count = miss_count_r;

endmodule

// File: tb/tb_imm_narrow.sv
// Bench for imm_narrow: one instance with zero-extension allowed, one without,
// fed identical streams and checked against a range-based reference model.
module tb_imm_narrow;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] value;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  imm_narrow_if a_if ();
  imm_narrow_if b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.value     = value;
  assign a_if.out_ready = out_ready;
  assign b_if.in_valid  = in_valid;
  assign b_if.value     = value;
  assign b_if.out_ready = out_ready;

  imm_narrow #(.ALLOW_ZERO(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  imm_narrow #(.ALLOW_ZERO(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: smallest width N in {5,8,11} whose signed or unsigned range holds v.
  function automatic logic [14:0] model_enc(input logic [15:0] v, input bit az);
    int sv;
    int uv;
    int n;
    int lim;
    sv = int'($signed(v));
    uv = int'(v);
    for (int k = 0; k < 3; k++) begin
      n   = 5 + 3 * k;
      lim = 1 << (n - 1);
      if (sv >= -lim && sv < lim) return {1'b1, 2'(k), 1'b1, 11'(uv & ((1 << n) - 1))};
      if (az && uv < (1 << n))    return {1'b1, 2'(k), 1'b0, 11'(uv & ((1 << n) - 1))};
    end
    return {1'b0, 2'b11, 1'b0, 11'd0};
  endfunction

  function automatic logic [14:0] res_a();
    return {a_if.fits, a_if.sel, a_if.sign_ext, a_if.imm};
  endfunction

  function automatic logic [14:0] res_b();
    return {b_if.fits, b_if.sel, b_if.sign_ext, b_if.imm};
  endfunction

  typedef struct {
    logic [15:0] v;
    int          acc;
  } item_t;

  item_t q[$];
  int    miss_a = 0;
  int    miss_b = 0;

  // Per-cycle compare against the in-flight queue model
  always @(negedge clk) begin
    bit          vexp;
    bit          rexp;
    logic [14:0] ea;
    logic [14:0] eb;
    if (!rst_n) begin
      q.delete();
      miss_a = 0;
      miss_b = 0;
    end else begin
      vexp = (q.size() > 0) && (q[0].acc <= edge_cnt - 1);
      rexp = (q.size() < 2) || out_ready;
      chk("out_valid_a", a_if.out_valid, vexp);
      chk("out_valid_b", b_if.out_valid, vexp);
      chk("in_ready_a", a_if.in_ready, rexp);
      chk("in_ready_b", b_if.in_ready, rexp);
      chk("miss_a", a_if.miss_count, miss_a);
      chk("miss_b", b_if.miss_count, miss_b);
      if (vexp) begin
        ea = model_enc(q[0].v, 1'b1);
        eb = model_enc(q[0].v, 1'b0);
        chk("enc_a", res_a(), ea);
        chk("enc_b", res_b(), eb);
        if (out_ready) begin
          if (!ea[14] && miss_a < 255) miss_a++;
          if (!eb[14] && miss_b < 255) miss_b++;
          void'(q.pop_front());
        end
      end
      if (in_valid && rexp) q.push_back('{v: value, acc: edge_cnt + 1});
    end
  end

  // Present v and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [15:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    value    = v;
    @(negedge clk);
    while (!a_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_if.in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send with out_ready=1 and pin the result one edge after acceptance.
  task automatic one(input string nm, input logic [15:0] v,
                     input logic [14:0] ea, input logic [14:0] eb);
    send(v);
    @(posedge clk);
    #1;
    chk({nm, "_vld"}, a_if.out_valid, 32'd1);
    chk({nm, "_a"}, res_a(), ea);
    chk({nm, "_b"}, res_b(), eb);
  endtask

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return 16'($urandom_range(0, 40) - 20);
      1:       return 16'($urandom_range(0, 300) - 150);
      2:       return 16'($urandom_range(0, 2200) - 1100);
      3:       return 16'($urandom_range(0, 2100));
      default: return 16'($urandom);
    endcase
  endfunction

  localparam logic [14:0] NOFIT = {1'b0, 2'b11, 1'b0, 11'd0};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    value     = 16'd0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", a_if.out_valid, 32'd0);
    chk("rst_in_ready", a_if.in_ready, 32'd1);
    chk("rst_result", res_a(), 32'd0);
    chk("rst_miss", a_if.miss_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    one("v000F", 16'h000F, {1'b1, 2'b00, 1'b1, 11'h00F}, {1'b1, 2'b00, 1'b1, 11'h00F});
    one("vFFF0", 16'hFFF0, {1'b1, 2'b00, 1'b1, 11'h010}, {1'b1, 2'b00, 1'b1, 11'h010});
    one("v001F", 16'h001F, {1'b1, 2'b00, 1'b0, 11'h01F}, {1'b1, 2'b01, 1'b1, 11'h01F});
    one("vFF80", 16'hFF80, {1'b1, 2'b01, 1'b1, 11'h080}, {1'b1, 2'b01, 1'b1, 11'h080});
    one("v03FF", 16'h03FF, {1'b1, 2'b10, 1'b1, 11'h3FF}, {1'b1, 2'b10, 1'b1, 11'h3FF});
    one("v0400", 16'h0400, {1'b1, 2'b10, 1'b0, 11'h400}, NOFIT);
    one("vFC00", 16'hFC00, {1'b1, 2'b10, 1'b1, 11'h400}, {1'b1, 2'b10, 1'b1, 11'h400});
    one("v0800", 16'h0800, NOFIT, NOFIT);
    one("v8000", 16'h8000, NOFIT, NOFIT);
    @(posedge clk);
    #1;
    chk("miss2_a", a_if.miss_count, 32'd2);
    chk("miss3_b", b_if.miss_count, 32'd3);

    // Back-pressure: two accepted, third held off until out_ready rises
    out_ready = 1'b0;
    in_valid  = 1'b1;
    value     = 16'h0001;
    @(posedge clk);
    #1;
    value = 16'h0020;
    @(posedge clk);
    #1;
    value = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", a_if.in_ready, 32'd0);
      chk("bp_hold", res_a(), {1'b1, 2'b00, 1'b1, 11'h001});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", a_if.in_ready, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_second", res_a(), {1'b1, 2'b01, 1'b1, 11'h020});
    @(posedge clk);
    #1;
    chk("bp_third", res_a(), {1'b1, 2'b10, 1'b1, 11'h100});
    @(posedge clk);
    #1;
    chk("bp_drained", a_if.out_valid, 32'd0);

    // Randomized traffic under random back-pressure
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      value     = rand_val();
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end

    // Saturation of the miss counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    value     = 16'h8000;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("miss_sat_a", a_if.miss_count, 32'd255);
    chk("miss_sat_b", b_if.miss_count, 32'd255);

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    value     = 16'h0003;
    @(posedge clk);
    #1;
    value = 16'h0800;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_full", a_if.in_ready, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", a_if.out_valid, 32'd0);
    chk("rst_mid_miss", a_if.miss_count, 32'd0);
    chk("rst_mid_miss_b", b_if.miss_count, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    one("v0005", 16'h0005, {1'b1, 2'b00, 1'b1, 11'h005}, {1'b1, 2'b00, 1'b1, 11'h005});
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
